// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch stage: owns the program counter, drives the instruction
// memory address and registers each fetched word into the IF/ID register.
// Redirects from EX override stalls and halts. A fetched halt word freezes
// fetch until a redirect or a reset arrives.

module fetch_stage #(
   parameter int              PC_W       = 32,
   parameter logic [PC_W-1:0] RESET_PC   = '0,
   parameter logic [31:0]     HALT_INSTR = 32'h0000_0000,
   parameter logic [31:0]     NOP_INSTR  = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirect_pc,
   output logic [PC_W-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] id_pc,
   output logic [31:0]     id_instr,
   output logic [6:0]      id_opcode,
   output logic            id_valid,
   output logic            halted,
   output logic [31:0]     fetch_count
);

   // Fetch either runs normally or sits frozen after fetching the halt word.
   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fetchState_t;

   fetchState_t     r_state;
   fetchState_t     w_stateNext;

   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] r_idPc;
   logic [31:0]     r_idInstr;
   logic            r_idValid;
   logic [31:0]     r_fetchCount;

   logic [PC_W-1:0] w_pcNext;
   logic [PC_W-1:0] w_idPcNext;
   logic [31:0]     w_idInstrNext;
   logic            w_idValidNext;
   logic [31:0]     w_fetchCountNext;

   logic [PC_W-1:0] w_pcPlus4;
   logic [PC_W-1:0] w_redirectTarget;
   logic            w_isHaltWord;

   // Sequential PC increment wraps naturally modulo 2^PC_W; redirect targets
   // are forced onto a word boundary by clearing the two low bits.
   assign w_pcPlus4        = r_pc + PC_W'(4);
   assign w_redirectTarget = redirect_pc & ~(PC_W'(3));
   assign w_isHaltWord     = (imem_rdata == HALT_INSTR);

   // State register: synchronous active-low reset puts everything back to
   // the power-on values regardless of stall, redirect or halt.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= ST_RUN;
         r_pc         <= RESET_PC;
         r_idPc       <= '0;
         r_idInstr    <= NOP_INSTR;
         r_idValid    <= 1'b0;
         r_fetchCount <= '0;
      end else begin
         r_state      <= w_stateNext;
         r_pc         <= w_pcNext;
         r_idPc       <= w_idPcNext;
         r_idInstr    <= w_idInstrNext;
         r_idValid    <= w_idValidNext;
         r_fetchCount <= w_fetchCountNext;
      end
   end

   // Next-state selection in priority order: redirect, halted, stall,
   // halt-word fetch, then normal sequential fetch. Everything holds by default.
   always_comb begin
      w_stateNext      = r_state;
      w_pcNext         = r_pc;
      w_idPcNext       = r_idPc;
      w_idInstrNext    = r_idInstr;
      w_idValidNext    = r_idValid;
      w_fetchCountNext = r_fetchCount;

      if (redirect) begin
         // A halt seen on the wrong path is discarded by the redirect.
         w_stateNext   = ST_RUN;
         w_pcNext      = w_redirectTarget;
         w_idInstrNext = NOP_INSTR;
         w_idValidNext = 1'b0;
      end else if (r_state == ST_HALT) begin
         w_idInstrNext = NOP_INSTR;
         w_idValidNext = 1'b0;
      end else if (stall) begin
         w_pcNext = r_pc;
      end else if (w_isHaltWord) begin
         w_stateNext   = ST_HALT;
         w_idInstrNext = NOP_INSTR;
         w_idValidNext = 1'b0;
      end else begin
         w_pcNext         = w_pcPlus4;
         w_idPcNext       = r_pc;
         w_idInstrNext    = imem_rdata;
         w_idValidNext    = 1'b1;
         w_fetchCountNext = r_fetchCount + 32'd1;
      end
   end

   // The stage does no decoding: the opcode is just the raw low seven bits,
   // so bubbles present the NOP opcode and downstream qualifies with id_valid.
   assign imem_addr   = r_pc;
   assign pc          = r_pc;
   assign id_pc       = r_idPc;
   assign id_instr    = r_idInstr;
   assign id_opcode   = r_idInstr[6:0];
   assign id_valid    = r_idValid;
   assign halted      = (r_state == ST_HALT);
   assign fetch_count = r_fetchCount;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// Directed walk through the fetch scenarios followed by randomized stall,
// redirect, reset and memory contents, all compared against a cycle-level
// behavioural model of the fetch stage kept here in the bench.

module tb_fetch_stage;

   localparam logic [31:0] HALT_W = 32'h0000_0000;
   localparam logic [31:0] NOP_W  = 32'h0000_0013;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic [6:0]  id_opcode;
   logic        id_valid;
   logic        halted;
   logic [31:0] fetch_count;

   logic [31:0] mem [64];

   int checkCount;
   int passCount;

   // Model state
   logic [31:0] mPc;
   logic [31:0] mIdPc;
   logic [31:0] mIdInstr;
   logic        mIdValid;
   logic        mHalted;
   logic [31:0] mCount;

   fetch_stage dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .pc          (pc),
      .id_pc       (id_pc),
      .id_instr    (id_instr),
      .id_opcode   (id_opcode),
      .id_valid    (id_valid),
      .halted      (halted),
      .fetch_count (fetch_count)
   );

   // Combinational instruction memory, word-indexed by the low address bits.
   assign imem_rdata = mem[imem_addr[7:2]];

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
   endtask

   // Compare every DUT output with the model.
   task automatic checkAll(input string tag);
      checkOutput({tag, ".pc"},       64'(pc),          64'(mPc));
      checkOutput({tag, ".addr"},     64'(imem_addr),   64'(mPc));
      checkOutput({tag, ".idPc"},     64'(id_pc),       64'(mIdPc));
      checkOutput({tag, ".idInstr"},  64'(id_instr),    64'(mIdInstr));
      checkOutput({tag, ".opcode"},   64'(id_opcode),   64'(mIdInstr & 32'h7F));
      checkOutput({tag, ".idValid"},  64'(id_valid),    64'(mIdValid));
      checkOutput({tag, ".halted"},   64'(halted),      64'(mHalted));
      checkOutput({tag, ".count"},    64'(fetch_count), 64'(mCount));
   endtask

   // Advance the model by one clock using the inputs currently applied,
   // let the DUT take the same edge, then compare just after it.
   task automatic applyStimulus(input string tag);
      logic [31:0] word;
      word = mem[mPc[7:2]];
      if (!reset) begin
         mPc = 32'h0; mIdPc = 32'h0; mIdInstr = NOP_W;
         mIdValid = 1'b0; mHalted = 1'b0; mCount = 32'h0;
      end else if (redirect) begin
         mPc = {redirect_pc[31:2], 2'b00};
         mIdInstr = NOP_W; mIdValid = 1'b0; mHalted = 1'b0;
      end else if (mHalted) begin
         mIdInstr = NOP_W; mIdValid = 1'b0;
      end else if (stall) begin
         mPc = mPc;
      end else if (word == HALT_W) begin
         mHalted = 1'b1; mIdInstr = NOP_W; mIdValid = 1'b0;
      end else begin
         mIdInstr = word; mIdPc = mPc; mIdValid = 1'b1;
         mPc = mPc + 32'd4; mCount = mCount + 32'd1;
      end
      @(posedge clk);
      #1;
      checkAll(tag);
   endtask

   function automatic logic [31:0] randWord();
      logic [31:0] w;
      w = $urandom;
      if (w == HALT_W) w = 32'h0000_0033;
      return w;
   endfunction

   initial begin
      checkCount = 0;
      passCount  = 0;
      reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      mPc = 32'h0; mIdPc = 32'h0; mIdInstr = NOP_W;
      mIdValid = 1'b0; mHalted = 1'b0; mCount = 32'h0;

      for (int i = 0; i < 64; i++) mem[i] = randWord();
      mem[0] = 32'h0050_0093;
      mem[1] = 32'h00A0_0113;
      mem[2] = 32'h0020_81B3;
      mem[3] = HALT_W;

      // Reset state
      @(negedge clk);
      applyStimulus("reset0");
      applyStimulus("reset1");
      checkOutput("resetInstr", 64'(id_instr), 64'h13);
      checkOutput("resetValid", 64'(id_valid), 64'h0);

      // Sequential fetch then stall with IF/ID holding pc=4
      reset = 1'b1;
      applyStimulus("seq0");
      checkOutput("seq0IdPc", 64'(id_pc), 64'h0);
      checkOutput("seq0Op",   64'(id_opcode), 64'h13);
      applyStimulus("seq1");
      checkOutput("seq1IdPc", 64'(id_pc), 64'h4);
      checkOutput("seq1Op",   64'(id_opcode), 64'h13);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus("stall");
         checkOutput("stallPc",    64'(pc), 64'h8);
         checkOutput("stallIdPc",  64'(id_pc), 64'h4);
         checkOutput("stallCount", 64'(fetch_count), 64'h2);
      end
      stall = 1'b0;
      applyStimulus("seq2");
      checkOutput("seq2IdPc",  64'(id_pc), 64'h8);
      checkOutput("seq2Op",    64'(id_opcode), 64'h33);
      checkOutput("seq2Count", 64'(fetch_count), 64'h3);

      // Halt word at 0xC, held for several cycles
      for (int i = 0; i < 4; i++) begin
         stall = (i == 2);
         applyStimulus("halt");
         checkOutput("haltFlag",  64'(halted), 64'h1);
         checkOutput("haltPc",    64'(pc), 64'hC);
         checkOutput("haltValid", 64'(id_valid), 64'h0);
         checkOutput("haltCount", 64'(fetch_count), 64'h3);
      end
      stall = 1'b0;

      // Redirect out of halt
      redirect = 1'b1; redirect_pc = 32'h20;
      applyStimulus("unhalt");
      checkOutput("unhaltFlag", 64'(halted), 64'h0);
      checkOutput("unhaltPc",   64'(pc), 64'h20);
      redirect = 1'b0;
      applyStimulus("resume");
      checkOutput("resumeIdPc",  64'(id_pc), 64'h20);
      checkOutput("resumeValid", 64'(id_valid), 64'h1);

      // Redirect with unaligned target while stalled
      redirect = 1'b1; redirect_pc = 32'h103; stall = 1'b1;
      applyStimulus("redir");
      checkOutput("redirPc",    64'(pc), 64'h100);
      checkOutput("redirValid", 64'(id_valid), 64'h0);
      redirect = 1'b0; stall = 1'b0;
      applyStimulus("redirTgt");
      checkOutput("redirIdPc",  64'(id_pc), 64'h100);
      checkOutput("redirValid2", 64'(id_valid), 64'h1);

      // PC wrap
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      applyStimulus("wrapA");
      redirect = 1'b0;
      applyStimulus("wrapB");
      checkOutput("wrapPc", 64'(pc), 64'h0);

      // Reset during a stall
      stall = 1'b1; reset = 1'b0;
      applyStimulus("rstStall");
      checkOutput("rstStallCount", 64'(fetch_count), 64'h0);
      checkOutput("rstStallInstr", 64'(id_instr), 64'h13);

      // Reset while halted
      stall = 1'b0; reset = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus("toHalt");
      checkOutput("toHaltFlag", 64'(halted), 64'h1);
      reset = 1'b0;
      applyStimulus("rstHalt");
      checkOutput("rstHaltFlag", 64'(halted), 64'h0);
      checkOutput("rstHaltPc",   64'(pc), 64'h0);
      reset = 1'b1;

      // Randomized phase with sporadic halt words in memory
      for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(0, 11) == 0) ? HALT_W : randWord();
      for (int n = 0; n < 600; n++) begin
         reset    = ($urandom_range(0, 49) != 0);
         stall    = ($urandom_range(0, 3) == 0);
         redirect = ($urandom_range(0, 7) == 0);
         redirect_pc = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
         applyStimulus("rand");
      end

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
